hs_rr_arbiter: RTL and testbench



---
 rtl/hs_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_hs_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_rr_arbiter.sv
// Four-requester round-robin arbiter and 4-phase req/ack sequencer.
// Picks a winner, latches its byte, runs req-up / ack-up / req-down / ack-down
// against the slave, then pulses done (or err on an ack timeout) back to it.
module hs_rr_arbiter #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      src_valid,
    input  logic [4*DW-1:0] src_data,
    output logic [3:0]      src_done,
    output logic [3:0]      src_err,
    output logic            req_out,
    output logic [DW-1:0]   data_out,
    input  logic            ack_in,
    output logic [1:0]      grant_id,
    output logic            busy,
    output logic [15:0]     xfer_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [15:0]     xfer_q, xfer_d;

    logic [DW-1:0]   src_bytes [4];
    logic            pick_found;
    logic [1:0]      pick_idx;
    logic [1:0]      cand;

    // Split the packed requester bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_bytes[i] = src_data[i*DW +: DW];
        end
    end

    // Round-robin search: first valid requester above the one served last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_grant_q;
        cand       = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!pick_found && src_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // State register and datapath registers; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            data_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            xfer_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            xfer_q       <= xfer_d;
        end
    end

    // Next-state logic; ack wins over the timeout in the same REQ cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        xfer_d       = xfer_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    data_d  = src_bytes[pick_idx];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (ack_in) begin
                    state_d = DROP;
                end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                    err_d   = 1'b1;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!ack_in) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                last_grant_d = grant_q;
                if (!err_q) begin
                    xfer_d = xfer_q + 16'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion pulses are decoded from FIN plus the registered grant/error.
    always_comb begin
        src_done = '0;
        src_err  = '0;
        if (state_q == FIN) begin
            if (err_q) begin
                src_err[grant_q] = 1'b1;
            end else begin
                src_done[grant_q] = 1'b1;
            end
        end
    end

    assign req_out    = (state_q == REQ);
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign data_out   = data_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter with a small behavioural slave model.
module tb_hs_rr_arbiter;

   localparam int DW      = 8;
   localparam int TIMEOUT = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      srcValid;
   logic [4*DW-1:0] srcData;
   logic [3:0]      srcDone;
   logic [3:0]      srcErr;
   logic            reqOut;
   logic [DW-1:0]   dataOut;
   logic            ackIn;
   logic [1:0]      grantId;
   logic            busy;
   logic [15:0]     xferCount;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int expXfer = 0;

   logic          slaveEn  = 1'b1;
   int            ackDelay = 1;
   int            reqCnt   = 0;
   logic [DW-1:0] lastByte = '0;

   hs_rr_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_valid  (srcValid),
      .src_data   (srcData),
      .src_done   (srcDone),
      .src_err    (srcErr),
      .req_out    (reqOut),
      .data_out   (dataOut),
      .ack_in     (ackIn),
      .grant_id   (grantId),
      .busy       (busy),
      .xfer_count (xferCount)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Absolute cycle counter used to measure pulse spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: raises ack ackDelay cycles after req rises, drops it one cycle after req falls.
   always @(posedge clk) begin
      if (rst) begin
         ackIn  <= 1'b0;
         reqCnt <= 0;
      end else if (reqOut) begin
         reqCnt <= reqCnt + 1;
         if (reqCnt == 0) lastByte <= dataOut;
         if (slaveEn && (reqCnt + 1 >= ackDelay)) ackIn <= 1'b1;
      end else begin
         reqCnt <= 0;
         ackIn  <= 1'b0;
      end
   end

   // Drive requester inputs; called at a falling edge.
   task automatic applyStimulus(input logic [3:0] valid, input logic [4*DW-1:0] data);
      srcData  = data;
      srcValid = valid;
   endtask

   // Step falling edges until a done/err pulse shows up or the budget runs out.
   task automatic waitPulse(input int budget, output logic [3:0] doneSeen, output logic [3:0] errSeen,
                            output int reqCycles, output int pulseCyc, output logic expired);
      doneSeen  = '0;
      errSeen   = '0;
      reqCycles = 0;
      pulseCyc  = 0;
      expired   = 1'b1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (reqOut) reqCycles++;
         if ((srcDone | srcErr) != 4'b0000) begin
            doneSeen = srcDone;
            errSeen  = srcErr;
            pulseCyc = i;
            expired  = 1'b0;
            break;
         end
      end
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      expXfer = 0;
   endtask

   task automatic test_reset();
      srcValid = '0;
      srcData  = '0;
      rst      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (reqOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", reqOut); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (dataOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", dataOut); end
      checks++; if (grantId !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant: got %0d expected 0", grantId); end
      checks++; if ((srcDone | srcErr) !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pulses: got done=%b err=%b expected 0", srcDone, srcErr); end
      checks++; if (xferCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_xfer: got %0d expected 0", xferCount); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [3:0] d, e; int rc, pc; logic exp;
      applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5});
      waitPulse(30, d, e, rc, pc, exp);
      srcValid = '0;
      checks++; if (exp) begin errors++; $display("[TB] FAIL single_timeout: no pulse within 30 cycles, expected done"); end
      checks++; if (rc !== 2) begin errors++; $display("[TB] FAIL single_req_cycles: got %0d expected 2", rc); end
      checks++; if (d !== 4'b0001 || e !== 4'b0000) begin errors++; $display("[TB] FAIL single_pulse: got done=%b err=%b expected done=0001", d, e); end
      checks++; if (pc !== 5) begin errors++; $display("[TB] FAIL single_pulse_cycle: got %0d expected 5", pc); end
      expXfer++;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: busy got %b expected 0", busy); end
      checks++; if (lastByte !== 8'hA5) begin errors++; $display("[TB] FAIL single_byte: got %h expected a5", lastByte); end
      checks++; if (dataOut !== 8'hA5) begin errors++; $display("[TB] FAIL single_data_hold: got %h expected a5", dataOut); end
      checks++; if (xferCount !== 16'(expXfer)) begin errors++; $display("[TB] FAIL single_xfer: got %0d expected %0d", xferCount, expXfer); end
   endtask

   task automatic test_round_robin();
      logic [3:0] d, e; int rc, pc; logic exp;
      int order [5] = '{0, 1, 2, 3, 0};
      logic [7:0] bytes [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
      int prevCyc = 0;
      pulseReset();
      applyStimulus(4'b1111, {8'h43, 8'h32, 8'h21, 8'h10});
      for (int k = 0; k < 5; k++) begin
         waitPulse(30, d, e, rc, pc, exp);
         if (k == 4) srcValid = '0;
         checks++; if (exp) begin errors++; $display("[TB] FAIL rr_timeout_%0d: no pulse within 30 cycles", k); end
         checks++; if (d !== (4'b0001 << order[k])) begin errors++; $display("[TB] FAIL rr_done_%0d: got %b expected %b", k, d, 4'b0001 << order[k]); end
         checks++; if (grantId !== 2'(order[k])) begin errors++; $display("[TB] FAIL rr_grant_%0d: got %0d expected %0d", k, grantId, order[k]); end
         checks++; if (lastByte !== bytes[order[k]]) begin errors++; $display("[TB] FAIL rr_byte_%0d: got %h expected %h", k, lastByte, bytes[order[k]]); end
         if (k > 0) begin
            checks++; if (cyc - prevCyc !== 6) begin errors++; $display("[TB] FAIL rr_spacing_%0d: got %0d expected 6", k, cyc - prevCyc); end
         end
         prevCyc = cyc;
         expXfer++;
      end
      @(negedge clk);
      checks++; if (xferCount !== 16'(expXfer)) begin errors++; $display("[TB] FAIL rr_xfer: got %0d expected %0d", xferCount, expXfer); end
   endtask

   task automatic test_fairness();
      logic [3:0] d, e; int rc, pc; logic exp;
      applyStimulus(4'b0101, {8'h00, 8'h77, 8'h00, 8'h55});
      waitPulse(30, d, e, rc, pc, exp);
      srcValid = 4'b0001;
      checks++; if (exp || d !== 4'b0100) begin errors++; $display("[TB] FAIL fair_first: got done=%b expired=%b expected 0100", d, exp); end
      checks++; if (lastByte !== 8'h77) begin errors++; $display("[TB] FAIL fair_first_byte: got %h expected 77", lastByte); end
      waitPulse(30, d, e, rc, pc, exp);
      srcValid = '0;
      checks++; if (exp || d !== 4'b0001) begin errors++; $display("[TB] FAIL fair_second: got done=%b expired=%b expected 0001", d, exp); end
      checks++; if (lastByte !== 8'h55) begin errors++; $display("[TB] FAIL fair_second_byte: got %h expected 55", lastByte); end
      expXfer += 2;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [3:0] d, e; int rc, pc; logic exp;
      slaveEn = 1'b0;
      applyStimulus(4'b0010, {8'h00, 8'h00, 8'h99, 8'h00});
      waitPulse(60, d, e, rc, pc, exp);
      srcValid = '0;
      checks++; if (exp) begin errors++; $display("[TB] FAIL to_expired: no pulse within 60 cycles, expected err"); end
      checks++; if (rc !== TIMEOUT) begin errors++; $display("[TB] FAIL to_req_cycles: got %0d expected %0d", rc, TIMEOUT); end
      checks++; if (e !== 4'b0010 || d !== 4'b0000) begin errors++; $display("[TB] FAIL to_pulse: got done=%b err=%b expected err=0010", d, e); end
      checks++; if (pc !== TIMEOUT + 2) begin errors++; $display("[TB] FAIL to_pulse_cycle: got %0d expected %0d", pc, TIMEOUT + 2); end
      @(negedge clk);
      checks++; if (xferCount !== 16'(expXfer)) begin errors++; $display("[TB] FAIL to_xfer: got %0d expected %0d", xferCount, expXfer); end
      slaveEn = 1'b1;
      applyStimulus(4'b0010, {8'h00, 8'h00, 8'h9A, 8'h00});
      waitPulse(30, d, e, rc, pc, exp);
      srcValid = '0;
      checks++; if (exp || d !== 4'b0010 || pc !== 5) begin errors++; $display("[TB] FAIL to_resume: got done=%b cycle=%0d expected 0010 at 5", d, pc); end
      expXfer++;
      @(negedge clk);
      checks++; if (xferCount !== 16'(expXfer)) begin errors++; $display("[TB] FAIL to_resume_xfer: got %0d expected %0d", xferCount, expXfer); end
   endtask

   task automatic test_late_ack();
      logic [3:0] d, e; int rc, pc; logic exp;
      ackDelay = TIMEOUT;
      applyStimulus(4'b0100, {8'h00, 8'h66, 8'h00, 8'h00});
      waitPulse(60, d, e, rc, pc, exp);
      srcValid = '0;
      checks++; if (exp || e !== 4'b0100 || d !== 4'b0000) begin errors++; $display("[TB] FAIL late1_pulse: got done=%b err=%b expected err=0100", d, e); end
      checks++; if (pc !== TIMEOUT + 3) begin errors++; $display("[TB] FAIL late1_cycle: got %0d expected %0d", pc, TIMEOUT + 3); end
      @(negedge clk);
      ackDelay = TIMEOUT - 1;
      applyStimulus(4'b0100, {8'h00, 8'h67, 8'h00, 8'h00});
      waitPulse(60, d, e, rc, pc, exp);
      srcValid = '0;
      checks++; if (exp || d !== 4'b0100 || e !== 4'b0000) begin errors++; $display("[TB] FAIL late0_pulse: got done=%b err=%b expected done=0100", d, e); end
      checks++; if (rc !== TIMEOUT) begin errors++; $display("[TB] FAIL late0_req_cycles: got %0d expected %0d", rc, TIMEOUT); end
      expXfer++;
      ackDelay = 1;
      @(negedge clk);
      checks++; if (xferCount !== 16'(expXfer)) begin errors++; $display("[TB] FAIL late_xfer: got %0d expected %0d", xferCount, expXfer); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] d, e; int rc, pc; logic exp;
      logic sawReq = 1'b0;
      logic inDrop = 1'b0;
      int pulses = 0;
      applyStimulus(4'b1000, {8'hC3, 8'h00, 8'h00, 8'h3C});
      for (int i = 0; i < 20 && !inDrop; i++) begin
         @(negedge clk);
         if (reqOut) sawReq = 1'b1;
         if (sawReq && busy && !reqOut) inDrop = 1'b1;
      end
      checks++; if (!inDrop) begin errors++; $display("[TB] FAIL rmid_reach_drop: got no DROP within 20 cycles, expected DROP"); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (reqOut !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_idle: got req=%b busy=%b expected 0 0", reqOut, busy); end
      checks++; if (xferCount !== 16'd0) begin errors++; $display("[TB] FAIL rmid_xfer: got %0d expected 0", xferCount); end
      if ((srcDone | srcErr) != 4'b0000) pulses++;
      rst = 1'b0;
      srcValid = '0;
      expXfer = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if ((srcDone | srcErr) != 4'b0000) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL rmid_no_pulse: got %0d pulses expected 0", pulses); end
      applyStimulus(4'b1001, {8'hC3, 8'h00, 8'h00, 8'h3C});
      waitPulse(30, d, e, rc, pc, exp);
      srcValid = 4'b1000;
      checks++; if (exp || d !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_first_grant: got done=%b expected 0001", d); end
      checks++; if (lastByte !== 8'h3C) begin errors++; $display("[TB] FAIL rmid_first_byte: got %h expected 3c", lastByte); end
      waitPulse(30, d, e, rc, pc, exp);
      srcValid = '0;
      checks++; if (exp || d !== 4'b1000) begin errors++; $display("[TB] FAIL rmid_second_grant: got done=%b expected 1000", d); end
      expXfer += 2;
      @(negedge clk);
      checks++; if (xferCount !== 16'(expXfer)) begin errors++; $display("[TB] FAIL rmid_xfer_after: got %0d expected %0d", xferCount, expXfer); end
   endtask

   task automatic test_wrap();
      logic [3:0] d, e; int rc, pc; logic exp;
      force dut.xfer_q = 16'hFFFF;
      @(negedge clk);
      release dut.xfer_q;
      @(negedge clk);
      checks++; if (xferCount !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preload: got %h expected ffff", xferCount); end
      applyStimulus(4'b0010, {8'h00, 8'h00, 8'hEE, 8'h00});
      waitPulse(30, d, e, rc, pc, exp);
      srcValid = '0;
      checks++; if (exp || d !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_done: got done=%b expected 0010", d); end
      @(negedge clk);
      checks++; if (xferCount !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_value: got %h expected 0000", xferCount); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      rst      = 1'b1;
      srcValid = '0;
      srcData  = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_timeout();
      test_late_ack();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net in case a scenario stalls forever.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
